// File: rtl/srl_pipe_ctrl.sv
// rtl/srl_pipe_ctrl.sv - ready/valid flow-control sequencer for an SRL_bus delay line
// Tracks a shadow valid bit per stage and provides flush/abort sequencing.
module srl_pipe_ctrl #(
  parameter int C_CLOCK_CYCLES = 4,
  parameter int C_CNT_WIDTH    = $clog2(C_CLOCK_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  input  logic                   abort,
  output logic                   flush_done,
  output logic                   busy,
  output logic [C_CNT_WIDTH-1:0] occupancy,
  output logic                   srl_ce,
  output logic                   srl_rst
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

  state_t                     state_q, state_d;
  logic [C_CLOCK_CYCLES-1:0]  vld_sr_q, vld_sr_d;
  logic [C_CNT_WIDTH-1:0]     occupancy_q, occupancy_d;
  logic                       flush_done_q, flush_done_d;
  logic                       busy_q, busy_d;
  logic                       accept;
  logic                       consume;

  // A stalled output word freezes the whole line, so ce is a single global enable.
  assign out_valid  = vld_sr_q[C_CLOCK_CYCLES-1];
  assign srl_ce     = (~out_valid | out_ready) & (state_q != ST_CLEAR);
  assign in_ready   = srl_ce & (state_q == ST_RUN);
  assign srl_rst    = (state_q == ST_CLEAR);
  assign accept     = in_valid & in_ready;
  assign consume    = out_valid & out_ready;
  assign occupancy  = occupancy_q;
  assign busy       = busy_q;
  assign flush_done = flush_done_q;

  always_comb begin
    state_d      = state_q;
    vld_sr_d     = vld_sr_q;
    occupancy_d  = occupancy_q;
    flush_done_d = 1'b0;

    if (srl_ce) begin
      vld_sr_d = {vld_sr_q[C_CLOCK_CYCLES-2:0], accept};
    end

    if (accept && !consume) begin
      occupancy_d = occupancy_q + CNT_ONE;
    end else if (!accept && consume) begin
      occupancy_d = occupancy_q - CNT_ONE;
    end

    case (state_q)
      ST_CLEAR: begin
        vld_sr_d    = '0;
        occupancy_d = '0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Drain completes on the cycle the last valid word leaves the line.
        if (occupancy_d == '0) begin
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    // Abort discards even a word handshaken in this same cycle.
    if (abort) begin
      state_d      = ST_CLEAR;
      vld_sr_d     = '0;
      occupancy_d  = '0;
      flush_done_d = 1'b0;
    end

    busy_d = (state_d != ST_RUN) || (occupancy_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_CLEAR;
      vld_sr_q     <= '0;
      occupancy_q  <= '0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      vld_sr_q     <= vld_sr_d;
      occupancy_q  <= occupancy_d;
      flush_done_q <= flush_done_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_srl_pipe_ctrl.sv
// tb/tb_srl_pipe_ctrl.sv - table-driven self-checking bench for srl_pipe_ctrl
// Beside the DUT sits a behavioural SRL_bus so word order can be scoreboarded.
module tb_srl_pipe_ctrl;

  localparam int N = 4;
  localparam int W = $clog2(N + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;
  logic         abort = 1'b0;
  logic         flush_done;
  logic         busy;
  logic [W-1:0] occupancy;
  logic         srl_ce;
  logic         srl_rst;

  srl_pipe_ctrl #(.C_CLOCK_CYCLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .abort      (abort),
    .flush_done (flush_done),
    .busy       (busy),
    .occupancy  (occupancy),
    .srl_ce     (srl_ce),
    .srl_rst    (srl_rst)
  );

  always #5 clk = ~clk;

  // Behavioural SRL_bus of depth N gated by the DUT.
  logic [7:0]   next_word = 8'd1;
  logic [8*N-1:0] srl_m = '0;
  logic [7:0]   data_out;
  assign data_out = srl_m[8*N-1 -: 8];

  always @(posedge clk) begin
    if (srl_rst) srl_m <= '0;
    else if (srl_ce) srl_m <= {srl_m[8*N-9:0], next_word};
  end

  typedef struct packed {
    logic       iv;
    logic       ordy;
    logic       fl;
    logic       ab;
    logic [8:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic add(input logic iv, input logic ordy, input logic fl, input logic ab,
                     input logic ir, input logic ov, input logic fd, input logic bz,
                     input int occ, input logic ce, input logic rs);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.ab = ab;
    v.exp = {ir, ov, fd, bz, ce, rs, 3'(occ)};
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
  endtask

  function automatic logic [8:0] outs();
    return {in_ready, out_valid, flush_done, busy, srl_ce, srl_rst, 3'(occupancy)};
  endfunction

  // Drive one cycle of inputs, sample on the falling edge, then step past the rising edge.
  task automatic apply(input vec_t v, input string nm, input int idx);
    logic acc;
    logic [7:0] w;
    in_valid = v.iv; out_ready = v.ordy; flush = v.fl; abort = v.ab;
    @(negedge clk);
    check(nm, idx, 16'(outs()), 16'(v.exp));
    check("popcount", idx, 16'(occupancy), 16'($countones(dut.vld_sr_q)));
    acc = in_valid & in_ready;
    if (abort) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL data[%0d]: got word %0d with none outstanding", idx, data_out);
        end else begin
          w = sb.pop_front();
          check("data", idx, 16'(data_out), 16'(w));
        end
      end
      if (acc) sb.push_back(next_word);
    end
    @(posedge clk);
    #1;
    if (acc) next_word = next_word + 8'd1;
  endtask

  localparam logic [8:0] RESET_OUTS = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0};

  initial begin
    // Fields: iv, ordy, fl, ab | in_ready, out_valid, flush_done, busy, occupancy, srl_ce, srl_rst
    add(0,0,0,0, 0,0,0,1,0,0,1);                       // CLEAR after reset release
    add(1,1,0,0, 1,0,0,0,0,1,0);                       // streaming words 1..8
    add(1,1,0,0, 1,0,0,1,1,1,0);
    add(1,1,0,0, 1,0,0,1,2,1,0);
    add(1,1,0,0, 1,0,0,1,3,1,0);
    for (int i = 0; i < 4; i++) add(1,1,0,0, 1,1,0,1,4,1,0);
    add(0,1,0,0, 1,1,0,1,4,1,0);
    add(0,1,0,0, 1,1,0,1,3,1,0);
    add(0,1,0,0, 1,1,0,1,2,1,0);
    add(0,1,0,0, 1,1,0,1,1,1,0);
    add(0,1,0,0, 1,0,0,0,0,1,0);
    add(1,1,0,0, 1,0,0,0,0,1,0);                       // bubbles 1,0,1,0
    add(0,1,0,0, 1,0,0,1,1,1,0);
    add(1,1,0,0, 1,0,0,1,1,1,0);
    add(0,1,0,0, 1,0,0,1,2,1,0);
    add(0,1,0,0, 1,1,0,1,2,1,0);
    add(0,1,0,0, 1,0,0,1,1,1,0);
    add(0,1,0,0, 1,1,0,1,1,1,0);
    add(0,1,0,0, 1,0,0,0,0,1,0);
    add(1,1,0,0, 1,0,0,0,0,1,0);                       // backpressure
    add(1,1,0,0, 1,0,0,1,1,1,0);
    add(1,1,0,0, 1,0,0,1,2,1,0);
    add(1,1,0,0, 1,0,0,1,3,1,0);
    for (int i = 0; i < 5; i++) add(1,0,0,0, 0,1,0,1,4,0,0);
    add(0,1,0,0, 1,1,0,1,4,1,0);
    add(0,1,0,0, 1,1,0,1,3,1,0);
    add(0,1,0,0, 1,1,0,1,2,1,0);
    add(0,1,0,0, 1,1,0,1,1,1,0);
    add(0,1,0,0, 1,0,0,0,0,1,0);
    add(1,1,0,0, 1,0,0,0,0,1,0);                       // flush with 3 words
    add(1,1,0,0, 1,0,0,1,1,1,0);
    add(1,1,0,0, 1,0,0,1,2,1,0);
    add(0,1,1,0, 1,0,0,1,3,1,0);
    add(1,1,0,0, 0,1,0,1,3,1,0);
    add(1,1,1,0, 0,1,0,1,2,1,0);
    add(0,1,0,0, 0,1,0,1,1,1,0);
    add(0,1,0,0, 1,0,1,0,0,1,0);
    add(0,1,0,0, 1,0,0,0,0,1,0);
    add(0,1,1,0, 1,0,0,0,0,1,0);                       // flush on empty line
    add(0,1,0,0, 0,0,0,1,0,1,0);
    add(0,1,0,0, 1,0,1,0,0,1,0);
    add(0,1,0,0, 1,0,0,0,0,1,0);
    add(1,1,0,0, 1,0,0,0,0,1,0);                       // abort with flush, line full
    add(1,1,0,0, 1,0,0,1,1,1,0);
    add(1,1,0,0, 1,0,0,1,2,1,0);
    add(1,1,0,0, 1,0,0,1,3,1,0);
    add(1,1,1,1, 1,1,0,1,4,1,0);
    add(1,1,1,0, 0,0,0,1,0,0,1);
    for (int i = 0; i < 4; i++) add(0,1,0,0, 1,0,0,0,0,1,0);

    rst = 1'b1;
    #1 rst = 1'b0;
    #2 check("reset_outs", 0, 16'(outs()), 16'(RESET_OUTS));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "row", i);

    // Async reset dropped mid-stream between clock edges.
    apply({1'b1, 1'b1, 1'b0, 1'b0, 9'b1_0_0_0_1_0_000}, "pre_rst", 0);
    apply({1'b1, 1'b1, 1'b0, 1'b0, 9'b1_0_0_1_1_0_001}, "pre_rst", 1);
    apply({1'b1, 1'b1, 1'b0, 1'b0, 9'b1_0_0_1_1_0_010}, "pre_rst", 2);
    #2 rst = 1'b0;
    #1 check("async_rst", 0, 16'(outs()), 16'(RESET_OUTS));
    sb.delete();
    @(posedge clk);
    #1 check("async_rst", 1, 16'(outs()), 16'(RESET_OUTS));
    rst = 1'b1;
    apply({1'b1, 1'b1, 1'b0, 1'b0, 9'b0_0_0_1_0_1_000}, "post_clear", 0);
    apply({1'b1, 1'b1, 1'b0, 1'b0, 9'b1_0_0_0_1_0_000}, "post_run", 0);
    apply({1'b0, 1'b1, 1'b0, 1'b0, 9'b1_0_0_1_1_0_001}, "post_run", 1);
    apply({1'b0, 1'b1, 1'b0, 1'b0, 9'b1_0_0_1_1_0_001}, "post_run", 2);
    apply({1'b0, 1'b1, 1'b0, 1'b0, 9'b1_0_0_1_1_0_001}, "post_run", 3);
    apply({1'b0, 1'b1, 1'b0, 1'b0, 9'b1_1_0_1_1_0_001}, "post_run", 4);
    apply({1'b0, 1'b1, 1'b0, 1'b0, 9'b1_0_0_0_1_0_000}, "post_run", 5);

    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL leftover: %0d words never emerged, required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
